pipe_stage_regs: RTL and testbench
==================================

# pipe_stage_regs

Pipeline register bank for the five-stage RV32I core. It holds the PC register and the F/D, D/E, E/M and M/W stage registers, and applies the stall and flush controls from the hazard unit. It also drives the stage-tagged register addresses and write-enables that the hazard unit compares, closing the loop between hazard detection and the datapath. A per-stage valid bit and a retired-instruction counter track bubbles through the pipe.

## Interface

**Parameters**
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, value loaded into PCF on reset.
- CNT_W, 32, width of the retired-instruction counter.

**Ports**
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- StallF, StallD, FlushD, FlushE  in  1 each  hazard controls.
- PCNextF  in  XLEN  next PC.
- InstrF  in  32  fetched instruction.
- PCPlus4F  in  XLEN  PC+4 from fetch.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode controls.
- ResultSrcD  in  2  decode result select.
- ALUControlD  in  3  decode ALU op.
- RD1D, RD2D, ImmExtD  in  XLEN  decode operands.
- ALUResultE, WriteDataE  in  XLEN  execute results.
- ReadDataM  in  XLEN  data-memory read.
- PCF  out  XLEN  fetch PC.
- InstrD, PCD, PCPlus4D  out  32/XLEN/XLEN  decode stage.
- Rs1D, Rs2D  out  5 each  InstrD[19:15], InstrD[24:20] (combinational).
- Execute-stage outputs: RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE (1 each), ResultSrcE (2), ALUControlE (3), RD1E, RD2E, ImmExtE, PCE, PCPlus4E (XLEN), Rs1E, Rs2E, RdE (5).
- ResultSrcEb0  out  1  ResultSrcE[0].
- Memory-stage outputs: RegWriteM, MemWriteM (1), ResultSrcM (2), ALUResultM, WriteDataM, PCPlus4M (XLEN), RdM (5).
- Writeback-stage outputs: RegWriteW (1), ResultSrcW (2), ALUResultW, ReadDataW, PCPlus4W (XLEN), RdW (5).
- ValidD, ValidE, ValidM, ValidW  out  1 each  stage-occupied flags.
- InstRet  out  CNT_W  count of valid instructions that have reached W.

## Operation

- RdD is InstrD[11:7]. It is internal and is latched into RdE.
- **PC register:** on reset, PCF = RESET_PC. Otherwise PCF ← PCNextF when !StallF, and holds when StallF.
- **F/D register**, priority order:
  - rst: clear.
  - FlushD: clear.
  - StallD: hold.
  - else: load InstrF, PCF, PCPlus4F, with ValidD ← 1.
  - "Clear" means all fields 0 and ValidD = 0. InstrD = 0 yields Rs1D = Rs2D = 0.
- **D/E register**, priority order:
  - rst: clear.
  - FlushE: clear.
  - else: load all D-stage fields plus Rs1D, Rs2D, RdD, with ValidE ← ValidD.
  - No stall input exists for this register. A cleared D/E register has RegWriteE = MemWriteE = JumpE = BranchE = 0 (bubble).
- **E/M register:** rst clears it; otherwise it always loads, with ValidM ← ValidE.
- **M/W register:** rst clears it; otherwise it always loads, with ValidW ← ValidM.
- **InstRet:** reset to 0. It increments by 1 on each clock edge where ValidW = 1 and rst = 0, and wraps modulo 2^CNT_W.
- **Simultaneous controls:**
  - FlushD with StallD: flush wins and D becomes a bubble.
  - StallF with FlushE: the PC holds and E is bubbled. This is the load-use case.
  - StallF with FlushD: the PC holds and D is bubbled.
- All outputs are registered except Rs1D, Rs2D and ResultSrcEb0, which are combinational slices.

## Timing

- Every register is rising-edge and single-cycle. Fetch to writeback takes 4 edges after PCF presents an address.
- All outputs are 0 during and after reset, except PCF = RESET_PC. This includes all Valid* flags and InstRet.
- Reset asserted mid-operation clears every stage on the same edge, regardless of stall or flush.
- Stall and flush inputs are sampled at the edge. Their effect is visible on outputs the cycle after.
- A load-use stall (StallF = StallD = FlushE = 1 for one cycle) holds PCF and InstrD for exactly one extra cycle and inserts exactly one bubble into E.

## Test plan

- **Reset:** rst high for 2 cycles with RESET_PC = 32'h100 → PCF = 32'h100; all stage fields, Valid* and InstRet = 0; drop rst, PCNextF = PCF+4 → PCF = 32'h104 after 1 edge.
- **Straight flow:** feed InstrF = 32'h00500093 (addi x1,x0,5) with RegWriteD = 1 → RdE = 1 at edge 2, RdM = 1 at edge 3, RdW = 1 and RegWriteW = 1 at edge 4, InstRet = 1 at edge 5.
- **Load-use:** lw x2 in E (ResultSrcE = 2'b01), pulse StallF = StallD = FlushE = 1 for one cycle → PCF and InstrD unchanged for one cycle; next cycle ValidE = 0, RegWriteE = 0, RdE = 0; the held instruction enters E one cycle late.
- **Taken branch:** FlushD = FlushE = 1 for one cycle → ValidD = ValidE = 0 with all control bits 0 next cycle; InstRet does not count the two squashed instructions.
- **Priority:** assert StallD and FlushD together → InstrD = 0 and ValidD = 0; assert rst with FlushE low and StallF high → PCF = RESET_PC.
- **Counter wrap:** CNT_W = 4, stream 17 valid instructions → InstRet goes 15 → 0 → 1.

Source files
------------

// File: rtl/pipe_stage_regs.sv
// Pipeline register bank for the five-stage RV32I core: PC, F/D, D/E, E/M and M/W
// registers with hazard-unit stall/flush handling, per-stage valid bits and a retire counter.
module pipe_stage_regs #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [XLEN-1:0]   PCNextF,
  input  logic [31:0]       InstrF,
  input  logic [XLEN-1:0]   PCPlus4F,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ResultSrcD,
  input  logic [2:0]        ALUControlD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   ALUResultE,
  input  logic [XLEN-1:0]   WriteDataE,
  input  logic [XLEN-1:0]   ReadDataM,
  output logic [XLEN-1:0]   PCF,
  output logic [31:0]       InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic [4:0]        Rs1D,
  output logic [4:0]        Rs2D,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic              ResultSrcEb0,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [4:0]        RdM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [XLEN-1:0]   ALUResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [XLEN-1:0]   PCPlus4W,
  output logic [4:0]        RdW,
  output logic              ValidD,
  output logic              ValidE,
  output logic              ValidM,
  output logic              ValidW,
  output logic [CNT_W-1:0]  InstRet
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic               valid;
  } fd_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic             jump;
    logic             branch;
    logic             alu_src;
    logic [1:0]       result_src;
    logic [2:0]       alu_control;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  imm_ext;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             valid;
  } de_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic [1:0]       result_src;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  write_data;
    logic [XLEN-1:0]  pc_plus4;
    logic [REG_W-1:0] rd;
    logic             valid;
  } em_t;

  typedef struct packed {
    logic             reg_write;
    logic [1:0]       result_src;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  read_data;
    logic [XLEN-1:0]  pc_plus4;
    logic [REG_W-1:0] rd;
    logic             valid;
  } mw_t;

  logic [XLEN-1:0]  pc_q, pc_d;
  fd_t              fd_q, fd_d;
  de_t              de_q, de_d;
  em_t              em_q, em_d;
  mw_t              mw_q, mw_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // Next-state for every stage; flush takes priority over stall in F/D.
  always_comb begin
    pc_d      = pc_q;
    fd_d      = fd_q;
    de_d      = '0;
    em_d      = '0;
    mw_d      = '0;
    instret_d = instret_q + CNT_W'(mw_q.valid);

    if (!StallF) begin
      pc_d = PCNextF;
    end

    if (FlushD) begin
      fd_d = '0;
    end else if (!StallD) begin
      fd_d.instr    = InstrF;
      fd_d.pc       = pc_q;
      fd_d.pc_plus4 = PCPlus4F;
      fd_d.valid    = 1'b1;
    end

    if (!FlushE) begin
      de_d.reg_write   = RegWriteD;
      de_d.mem_write   = MemWriteD;
      de_d.jump        = JumpD;
      de_d.branch      = BranchD;
      de_d.alu_src     = ALUSrcD;
      de_d.result_src  = ResultSrcD;
      de_d.alu_control = ALUControlD;
      de_d.rd1         = RD1D;
      de_d.rd2         = RD2D;
      de_d.imm_ext     = ImmExtD;
      de_d.pc          = fd_q.pc;
      de_d.pc_plus4    = fd_q.pc_plus4;
      de_d.rs1         = fd_q.instr[19:15];
      de_d.rs2         = fd_q.instr[24:20];
      de_d.rd          = fd_q.instr[11:7];
      de_d.valid       = fd_q.valid;
    end

    em_d.reg_write  = de_q.reg_write;
    em_d.mem_write  = de_q.mem_write;
    em_d.result_src = de_q.result_src;
    em_d.alu_result = ALUResultE;
    em_d.write_data = WriteDataE;
    em_d.pc_plus4   = de_q.pc_plus4;
    em_d.rd         = de_q.rd;
    em_d.valid      = de_q.valid;

    mw_d.reg_write  = em_q.reg_write;
    mw_d.result_src = em_q.result_src;
    mw_d.alu_result = em_q.alu_result;
    mw_d.read_data  = ReadDataM;
    mw_d.pc_plus4   = em_q.pc_plus4;
    mw_d.rd         = em_q.rd;
    mw_d.valid      = em_q.valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= XLEN'(RESET_PC);
      fd_q      <= '0;
      de_q      <= '0;
      em_q      <= '0;
      mw_q      <= '0;
      instret_q <= '0;
    end else begin
      pc_q      <= pc_d;
      fd_q      <= fd_d;
      de_q      <= de_d;
      em_q      <= em_d;
      mw_q      <= mw_d;
      instret_q <= instret_d;
    end
  end

  assign PCF          = pc_q;
  assign InstrD       = fd_q.instr;
  assign PCD          = fd_q.pc;
  assign PCPlus4D     = fd_q.pc_plus4;
  assign ValidD       = fd_q.valid;
  assign Rs1D         = fd_q.instr[19:15];
  assign Rs2D         = fd_q.instr[24:20];

  assign RegWriteE    = de_q.reg_write;
  assign MemWriteE    = de_q.mem_write;
  assign JumpE        = de_q.jump;
  assign BranchE      = de_q.branch;
  assign ALUSrcE      = de_q.alu_src;
  assign ResultSrcE   = de_q.result_src;
  assign ALUControlE  = de_q.alu_control;
  assign RD1E         = de_q.rd1;
  assign RD2E         = de_q.rd2;
  assign ImmExtE      = de_q.imm_ext;
  assign PCE          = de_q.pc;
  assign PCPlus4E     = de_q.pc_plus4;
  assign Rs1E         = de_q.rs1;
  assign Rs2E         = de_q.rs2;
  assign RdE          = de_q.rd;
  assign ValidE       = de_q.valid;
  assign ResultSrcEb0 = de_q.result_src[0];

  assign RegWriteM    = em_q.reg_write;
  assign MemWriteM    = em_q.mem_write;
  assign ResultSrcM   = em_q.result_src;
  assign ALUResultM   = em_q.alu_result;
  assign WriteDataM   = em_q.write_data;
  assign PCPlus4M     = em_q.pc_plus4;
  assign RdM          = em_q.rd;
  assign ValidM       = em_q.valid;

  assign RegWriteW    = mw_q.reg_write;
  assign ResultSrcW   = mw_q.result_src;
  assign ALUResultW   = mw_q.alu_result;
  assign ReadDataW    = mw_q.read_data;
  assign PCPlus4W     = mw_q.pc_plus4;
  assign RdW          = mw_q.rd;
  assign ValidW       = mw_q.valid;

  assign InstRet      = instret_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Bench for pipe_stage_regs: directed control table, counter-wrap sequence and random
// stimulus, all checked against an instruction-slot model of the pipe.
module tb_pipe_stage_regs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] RPC   = 32'h100;

  logic clk = 1'b0;
  logic rst, StallF, StallD, FlushD, FlushE;
  logic [31:0] PCNextF, InstrF, PCPlus4F;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic [31:0] RD1D, RD2D, ImmExtD, ALUResultE, WriteDataE, ReadDataM;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcEb0;
  logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW;
  logic [2:0] ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic RegWriteM, MemWriteM, RegWriteW;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, ALUResultW, ReadDataW, PCPlus4W;
  logic ValidD, ValidE, ValidM, ValidW;
  logic [CNT_W-1:0] InstRet;

  pipe_stage_regs #(.XLEN(XLEN), .RESET_PC(RPC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .ReadDataM(ReadDataM),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcEb0(ResultSrcEb0),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
    .ValidD(ValidD), .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW), .InstRet(InstRet)
  );

  always #5 clk = ~clk;

  // One instruction as it travels down the pipe; register fields come from instr.
  typedef struct packed {
    logic        v;
    logic [31:0] instr, pc, pc4;
    logic        rw, mw, j, b, as;
    logic [1:0]  rs;
    logic [2:0]  ac;
    logic [31:0] rd1, rd2, imm, alu, wd, rdata;
  } slot_t;

  slot_t sd, se, sm, sw;
  logic [31:0] m_pc;
  logic [CNT_W-1:0] m_cnt;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    chk("pcf", 256'(PCF), 256'(m_pc));
    chk("d_stage", 256'({InstrD, PCD, PCPlus4D, ValidD, Rs1D, Rs2D}),
        256'({sd.instr, sd.pc, sd.pc4, sd.v, sd.instr[19:15], sd.instr[24:20]}));
    chk("e_stage", 256'({RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
                         RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE, ResultSrcEb0}),
        256'({se.rw, se.mw, se.j, se.b, se.as, se.rs, se.ac, se.rd1, se.rd2, se.imm, se.pc, se.pc4,
              se.instr[19:15], se.instr[24:20], se.instr[11:7], se.v, se.rs[0]}));
    chk("m_stage", 256'({RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM, ValidM}),
        256'({sm.rw, sm.mw, sm.rs, sm.alu, sm.wd, sm.pc4, sm.instr[11:7], sm.v}));
    chk("w_stage", 256'({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW, ValidW, InstRet}),
        256'({sw.rw, sw.rs, sw.alu, sw.rdata, sw.pc4, sw.instr[11:7], sw.v, m_cnt}));
  endtask

  // Advance the model with the current inputs, clock the DUT, then compare.
  task automatic tick();
    slot_t nd, ne, nm, nw;
    logic [31:0] npc;
    logic [CNT_W-1:0] ncnt;
    if (rst) begin
      npc = RPC; nd = '0; ne = '0; nm = '0; nw = '0; ncnt = '0;
    end else begin
      ncnt = m_cnt + CNT_W'(sw.v);
      nw = sm; nw.rdata = ReadDataM;
      nm = se; nm.alu = ALUResultE; nm.wd = WriteDataE;
      if (FlushE) ne = '0;
      else begin
        ne = sd;
        ne.rw = RegWriteD; ne.mw = MemWriteD; ne.j = JumpD; ne.b = BranchD; ne.as = ALUSrcD;
        ne.rs = ResultSrcD; ne.ac = ALUControlD;
        ne.rd1 = RD1D; ne.rd2 = RD2D; ne.imm = ImmExtD;
      end
      if (FlushD) nd = '0;
      else if (StallD) nd = sd;
      else begin
        nd = '0; nd.v = 1'b1; nd.instr = InstrF; nd.pc = m_pc; nd.pc4 = PCPlus4F;
      end
      npc = StallF ? m_pc : PCNextF;
    end
    @(posedge clk);
    #1;
    m_pc = npc; sd = nd; se = ne; sm = nm; sw = nw; m_cnt = ncnt;
    check_all();
  endtask

  task automatic rand_data();
    PCNextF = $urandom; InstrF = $urandom; PCPlus4F = $urandom;
    RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); JumpD = 1'($urandom);
    BranchD = 1'($urandom); ALUSrcD = 1'($urandom);
    ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
    ALUResultE = $urandom; WriteDataE = $urandom; ReadDataM = $urandom;
  endtask

  typedef struct {
    logic rst, sf, sd, fd, fe;
    logic [31:0] pcn, instr, e_pcf, e_instr_d;
    logic e_vd, e_ve;
    logic [4:0] e_rde;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Reset, addi / lw / dependent add, load-use stall, taken branch, stall+flush, reset while stalled.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h100, 32'h0,        1'b0, 1'b0, 5'd0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h100, 32'h0,        1'b0, 1'b0, 5'd0, 4'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 32'h00500093, 32'h104, 32'h00500093, 1'b1, 1'b0, 5'd0, 4'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 32'h00002103, 32'h108, 32'h00002103, 1'b1, 1'b1, 5'd1, 4'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10C, 32'h001101B3, 32'h10C, 32'h001101B3, 1'b1, 1'b1, 5'd2, 4'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h110, 32'h00418213, 32'h10C, 32'h001101B3, 1'b1, 1'b0, 5'd0, 4'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h110, 32'h00418213, 32'h110, 32'h00418213, 1'b1, 1'b1, 5'd3, 4'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h00520293, 32'h200, 32'h0,        1'b0, 1'b0, 5'd0, 4'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h204, 32'h00628313, 32'h204, 32'h0,        1'b0, 1'b0, 5'd0, 4'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h208, 32'h00730393, 32'h208, 32'h00730393, 1'b1, 1'b0, 5'd0, 4'd3};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20C, 32'h00838413, 32'h100, 32'h0,        1'b0, 1'b0, 5'd0, 4'd0};

    sd = '0; se = '0; sm = '0; sw = '0; m_pc = '0; m_cnt = '0;
    rand_data();
    RegWriteD = 1'b1; MemWriteD = 1'b0; JumpD = 1'b0; BranchD = 1'b0; ALUSrcD = 1'b1;
    ResultSrcD = 2'b00; ALUControlD = 3'b000;

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; StallF = tbl[i].sf; StallD = tbl[i].sd;
      FlushD = tbl[i].fd; FlushE = tbl[i].fe;
      PCNextF = tbl[i].pcn; InstrF = tbl[i].instr; PCPlus4F = tbl[i].pcn;
      tick();
      chk("tbl_pcf", 256'(PCF), 256'(tbl[i].e_pcf));
      chk("tbl_instr_d", 256'(InstrD), 256'(tbl[i].e_instr_d));
      chk("tbl_valid_de", 256'({ValidD, ValidE}), 256'({tbl[i].e_vd, tbl[i].e_ve}));
      chk("tbl_rd_e", 256'(RdE), 256'(tbl[i].e_rde));
      chk("tbl_instret", 256'(InstRet), 256'(tbl[i].e_cnt));
      if (tbl[i].fe) chk("tbl_bubble_ctrl", 256'({RegWriteE, MemWriteE, JumpE, BranchE}), 256'(0));
    end

    // Unbroken stream: first instruction retires after edge 5, so the count is (k-4) mod 16.
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      rand_data();
      tick();
      chk("instret_stream", 256'(InstRet), 256'((k < 4) ? 0 : ((k - 4) % 16)));
    end

    // Random controls with occasional reset.
    for (int n = 0; n < 2000; n++) begin
      rand_data();
      rst    = ($urandom_range(63) == 0);
      StallF = ($urandom_range(3) == 0);
      StallD = ($urandom_range(3) == 0);
      FlushD = ($urandom_range(4) == 0);
      FlushE = ($urandom_range(4) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
